// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter client agents.
package rr_pkg;

    localparam int unsigned RR_ACK_LAT = 2;
    localparam int unsigned RR_WASTE_W = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_requester_if.sv
// Job-in / request-grant / job-out handshake bundle for one arbiter port.
interface rr_requester_if #(
    parameter int unsigned DW = 8
) ();

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          req;
    logic          ack;
    logic          out_valid;
    logic [DW-1:0] out_data;

    modport master (
        input  in_valid, in_data, ack,
        output in_ready, req, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, ack,
        input  in_ready, req, out_valid, out_data
    );

endinterface

// File: rtl/rr_job_fifo.sv
// DW x DEPTH synchronous job FIFO; full/empty decoded from the count register.
module rr_job_fifo
    import rr_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DW-1:0]           wdata,
    output logic [DW-1:0]           rdata,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/rr_requester.sv
// Client agent for one arbiter port: queues jobs, requests while non-empty,
// pops one job per ack, and tracks wasted grants and starvation.
module rr_requester
    import rr_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                   clock,
    input  logic                   reset_n,
    rr_requester_if.master         bus,
    output logic [clog2(DEPTH):0]  count,
    output logic [RR_WASTE_W-1:0]  wasted,
    output logic                   starve,
    input  logic                   clr_err
);

    localparam int unsigned WW = clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [DW-1:0] rdata;
    logic [WW-1:0] wait_cnt;

    rr_job_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (bus.in_data),
        .rdata   (rdata),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // An ack against an empty queue never consumes a same-edge push.
    assign push         = bus.in_valid & ~full;
    assign pop          = bus.ack & ~empty;
    assign bus.in_ready = ~full;
    assign bus.req      = (count != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= pop;
            if (pop) bus.out_data <= rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || clr_err) begin
            wasted <= '0;
        end else if (bus.ack && empty && wasted != '1) begin
            wasted <= wasted + RR_WASTE_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            starve   <= 1'b0;
        end else begin
            if (!bus.req || bus.ack) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            if (clr_err) begin
                starve <= 1'b0;
            end else if (bus.req && !bus.ack && wait_cnt == WAIT_MAX - WW'(1)) begin
                starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_requester.sv
// Scenario bench for rr_requester: expected jobs are queued when pushed and
// compared against out_data whenever out_valid is observed.
module tb_rr_requester;

    logic       clock;
    logic       reset_n;
    logic       clr_err;
    logic [2:0] count;
    logic [7:0] wasted;
    logic       starve;

    rr_requester_if #(.DW(8)) bus ();

    rr_requester #(
        .DW       (8),
        .DEPTH    (4),
        .MAX_WAIT (15)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .count   (count),
        .wasted  (wasted),
        .starve  (starve),
        .clr_err (clr_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_d;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.ack      = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        n_cmp++; if (bus.req !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got req=%b rdy=%b want 0/1", bus.req, bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_out: got v=%b d=%h want 0/00", bus.out_valid, bus.out_data); end
        n_cmp++; if (wasted !== 8'd0 || starve !== 1'b0) begin n_err++; $display("FAIL rst_err: got wasted=%0d starve=%b want 0/0", wasted, starve); end
        // mid-run reset discards queued jobs
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + i);
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL midrst_pre_count: got %0d want 3", count); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        n_cmp++; if (bus.req !== 1'b0 || count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || wasted !== 8'd0) begin
            n_err++; $display("FAIL midrst_state: got req=%b count=%0d v=%b rdy=%b wasted=%0d want 0/0/0/1/0", bus.req, count, bus.out_valid, bus.in_ready, wasted);
        end
    endtask

    task automatic test_single();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        sb.push_back(8'hA5);
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.req !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_req_rise: got req=%b v=%b want 1/0", bus.req, bus.out_valid); end
        step();
        n_cmp++; if (bus.req !== 1'b1) begin n_err++; $display("FAIL single_req_hold: got %b want 1", bus.req); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid);
        end else begin
            exp_d = sb.pop_front();
            if (bus.out_data !== exp_d) begin n_err++; $display("FAIL single_out_data: got %h want %h", bus.out_data, exp_d); end
        end
        n_cmp++; if (bus.req !== 1'b0) begin n_err++; $display("FAIL single_req_fall: got %b want 0", bus.req); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5) begin n_err++; $display("FAIL single_hold: got v=%b d=%h want 0/a5", bus.out_valid, bus.out_data); end
    endtask

    task automatic drain(input int n, input string tag);
        bus.ack = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, i, bus.out_valid);
            end else begin
                exp_d = sb.pop_front();
                if (bus.out_data !== exp_d) begin n_err++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, bus.out_data, exp_d); end
            end
        end
        bus.ack = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            sb.push_back(8'(i));
            step();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0 || count !== 3'd4) begin n_err++; $display("FAIL fill_full: got rdy=%b count=%0d want 0/4", bus.in_ready, count); end
        drain(4, "fill_drain");
        n_cmp++; if (count !== 3'd0 || wasted !== 8'd0) begin n_err++; $display("FAIL fill_empty: got count=%0d wasted=%0d want 0/0", count, wasted); end
    endtask

    task automatic test_back_to_back();
        for (int i = 5; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            sb.push_back(8'(i));
            step();
        end
        bus.in_valid = 1'b0;
        drain(1, "b2b_first");
        n_cmp++; if (count !== 3'd3 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_count_a: got count=%0d rdy=%b want 3/1", count, bus.in_ready); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h09;
        sb.push_back(8'h09);
        drain(1, "b2b_pushpop");
        bus.in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL b2b_count_b: got %0d want 3", count); end
        drain(3, "b2b_tail");
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_empty: got %0d want 0", count); end
    endtask

    task automatic test_wasted();
        bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL wasted_nov[%0d]: got %b want 0", i, bus.out_valid); end
        end
        n_cmp++; if (wasted !== 8'd3) begin n_err++; $display("FAIL wasted_cnt: got %0d want 3", wasted); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if (wasted !== 8'd0) begin n_err++; $display("FAIL wasted_clr: got %0d want 0", wasted); end
        // push on the same edge as an ack to an empty queue is kept
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        sb.push_back(8'h77);
        step();
        bus.in_valid = 1'b0;
        bus.ack      = 1'b0;
        n_cmp++; if (count !== 3'd1 || bus.out_valid !== 1'b0 || wasted !== 8'd1) begin
            n_err++; $display("FAIL wasted_push: got count=%0d v=%b wasted=%0d want 1/0/1", count, bus.out_valid, wasted);
        end
        drain(1, "wasted_kept");
        bus.ack = 1'b1;
        repeat (260) step();
        bus.ack = 1'b0;
        n_cmp++; if (wasted !== 8'd255) begin n_err++; $display("FAIL wasted_sat: got %0d want 255", wasted); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if (wasted !== 8'd0) begin n_err++; $display("FAIL wasted_clr2: got %0d want 0", wasted); end
    endtask

    task automatic test_starve();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        sb.push_back(8'h3C);
        step();
        bus.in_valid = 1'b0;
        repeat (14) step();
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_early: got %b want 0", starve); end
        step();
        n_cmp++; if (starve !== 1'b1) begin n_err++; $display("FAIL starve_set: got %b want 1", starve); end
        drain(1, "starve_pop");
        n_cmp++; if (starve !== 1'b1) begin n_err++; $display("FAIL starve_sticky: got %b want 1", starve); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        n_cmp++; if (starve !== 1'b0) begin n_err++; $display("FAIL starve_clr: got %b want 0", starve); end
        step();
        n_cmp++; if (starve !== 1'b0 || sb.size() != 0) begin n_err++; $display("FAIL starve_final: got starve=%b sb=%0d want 0/0", starve, sb.size()); end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_wasted();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
